// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core constants, the decoded stage control bundle and
//                the writeback-forwarding qualification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 16;

    // Decoded control bundle carried from ID to EX; opaque to this stage.
    typedef struct packed {
        logic [3:0] alu_op;
        logic [3:0] fu_sel;
        logic [7:0] misc;
    } stage_ctrl_t;

    // A writeback port forwards to a source when it is active, targets the
    // same register in the same class, and the source is not integer x0.
    function automatic logic fwd_qualify(
        input logic en,
        input logic addr_eq,
        input logic wb_is_fp,
        input logic src_is_fp,
        input logic src_addr_zero
    );
        return en && addr_eq && (wb_is_fp == src_is_fp) &&
               !(src_addr_zero && !src_is_fp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg_if
//  Description : Decode-side, writeback and EX-side signals of the ID/EX
//                stage register. master = surrounding pipeline, slave = stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_reg_if #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int RA_W   = core_pkg::RA_W,
    parameter int NUM_WB = 2,
    parameter int CTRL_W = core_pkg::CTRL_W
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_imm;
    logic [RA_W-1:0]          in_rd;
    logic [RA_W-1:0]          in_rs1;
    logic [RA_W-1:0]          in_rs2;
    logic                     in_rs1_fp;
    logic                     in_rs2_fp;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [XLEN-1:0]          rs1_int_data;
    logic [XLEN-1:0]          rs2_int_data;
    logic [XLEN-1:0]          rs1_fp_data;
    logic [XLEN-1:0]          rs2_fp_data;
    logic [NUM_WB-1:0]        wb_en;
    logic [NUM_WB-1:0]        wb_fp;
    logic [NUM_WB*RA_W-1:0]   wb_rd;
    logic [NUM_WB*XLEN-1:0]   wb_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_imm;
    logic [RA_W-1:0]          out_rd;
    logic [RA_W-1:0]          out_rs1;
    logic [RA_W-1:0]          out_rs2;
    logic                     out_rs1_fp;
    logic                     out_rs2_fp;
    logic [XLEN-1:0]          out_rs1_data;
    logic [XLEN-1:0]          out_rs2_data;
    logic [CTRL_W-1:0]        out_ctrl;

    modport master (
        output flush, in_valid, in_pc, in_imm, in_rd, in_rs1, in_rs2,
               in_rs1_fp, in_rs2_fp, in_ctrl, rs1_int_data, rs2_int_data,
               rs1_fp_data, rs2_fp_data, wb_en, wb_fp, wb_rd, wb_data,
               out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1,
               out_rs2, out_rs1_fp, out_rs2_fp, out_rs1_data, out_rs2_data,
               out_ctrl
    );

    modport slave (
        input  flush, in_valid, in_pc, in_imm, in_rd, in_rs1, in_rs2,
               in_rs1_fp, in_rs2_fp, in_ctrl, rs1_int_data, rs2_int_data,
               rs1_fp_data, rs2_fp_data, wb_en, wb_fp, wb_rd, wb_data,
               out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1,
               out_rs2, out_rs1_fp, out_rs2_fp, out_rs1_data, out_rs2_data,
               out_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Priority forwarding mux. Selects the data of the lowest
//                indexed writeback port that hits (addr, is_fp), otherwise
//                passes the default data through.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int NUM_WB = 2
) (
    input  wire logic [RA_W-1:0]          addr,
    input  wire logic                     is_fp,
    input  wire logic [XLEN-1:0]          dflt_data,
    input  wire logic [NUM_WB-1:0]        wb_en,
    input  wire logic [NUM_WB-1:0]        wb_fp,
    input  wire logic [NUM_WB*RA_W-1:0]   wb_rd,
    input  wire logic [NUM_WB*XLEN-1:0]   wb_data,
    output logic      [XLEN-1:0]          data
);
    import core_pkg::*;

    // Walk from the oldest port to the youngest so port 0 has the last word.
    always_comb begin
        data = dflt_data;
        for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (fwd_qualify(wb_en[i], wb_rd[i*RA_W +: RA_W] == addr,
                            wb_fp[i], is_fp, addr == '0)) begin
                data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg
//  Description : ID/EX pipeline register with valid/ready handshake, flush,
//                int/FP operand select, writeback forwarding on load and
//                operand refresh while the entry is stalled in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int NUM_WB = 2,
    parameter int CTRL_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    id_ex_stage_reg_if.slave  bus
);
    import core_pkg::*;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [RA_W-1:0]   ex_rd;
    logic [RA_W-1:0]   ex_rs1;
    logic [RA_W-1:0]   ex_rs2;
    logic              ex_rs1_fp;
    logic              ex_rs2_fp;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;

    logic              load;
    logic              fire;
    logic [XLEN-1:0]   ld_rs1_data;
    logic [XLEN-1:0]   ld_rs2_data;
    logic [XLEN-1:0]   rf_rs1_data;
    logic [XLEN-1:0]   rf_rs2_data;

    assign bus.in_ready = !ex_valid || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;
    assign fire         = ex_valid && bus.out_ready;

    // Operands for an incoming entry: register file data overridden by writeback.
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .NUM_WB(NUM_WB)) u_fwd_ld_rs1 (
        .addr(bus.in_rs1), .is_fp(bus.in_rs1_fp),
        .dflt_data(bus.in_rs1_fp ? bus.rs1_fp_data : bus.rs1_int_data),
        .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd),
        .wb_data(bus.wb_data), .data(ld_rs1_data)
    );
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .NUM_WB(NUM_WB)) u_fwd_ld_rs2 (
        .addr(bus.in_rs2), .is_fp(bus.in_rs2_fp),
        .dflt_data(bus.in_rs2_fp ? bus.rs2_fp_data : bus.rs2_int_data),
        .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd),
        .wb_data(bus.wb_data), .data(ld_rs2_data)
    );

    // Operands for the held entry: current value overridden by writeback.
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .NUM_WB(NUM_WB)) u_fwd_rf_rs1 (
        .addr(ex_rs1), .is_fp(ex_rs1_fp), .dflt_data(ex_rs1_data),
        .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd),
        .wb_data(bus.wb_data), .data(rf_rs1_data)
    );
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .NUM_WB(NUM_WB)) u_fwd_rf_rs2 (
        .addr(ex_rs2), .is_fp(ex_rs2_fp), .dflt_data(ex_rs2_data),
        .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd),
        .wb_data(bus.wb_data), .data(rf_rs2_data)
    );

    // Entry register: flush beats load, load beats drain, a stalled entry refreshes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_fp   <= 1'b0;
            ex_rs2_fp   <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
        end else if (bus.flush) begin
            ex_valid    <= 1'b0;
        end else if (load) begin
            ex_valid    <= 1'b1;
            ex_pc       <= bus.in_pc;
            ex_imm      <= bus.in_imm;
            ex_rd       <= bus.in_rd;
            ex_rs1      <= bus.in_rs1;
            ex_rs2      <= bus.in_rs2;
            ex_rs1_fp   <= bus.in_rs1_fp;
            ex_rs2_fp   <= bus.in_rs2_fp;
            ex_rs1_data <= ld_rs1_data;
            ex_rs2_data <= ld_rs2_data;
        end else if (fire) begin
            ex_valid    <= 1'b0;
        end else if (ex_valid) begin
            ex_rs1_data <= rf_rs1_data;
            ex_rs2_data <= rf_rs2_data;
        end
    end

    generate
        if (CTRL_W == $bits(stage_ctrl_t)) begin : g_ctrl_typed
            stage_ctrl_t ctrl_q;
            // Control bundle held in its structured form; it only changes on load.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    ctrl_q <= '0;
                end else if (load) begin
                    ctrl_q <= stage_ctrl_t'(bus.in_ctrl);
                end
            end
            assign bus.out_ctrl = ctrl_q;
        end else begin : g_ctrl_raw
            logic [CTRL_W-1:0] ctrl_q;
            // Control bundle held as a raw vector; it only changes on load.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    ctrl_q <= '0;
                end else if (load) begin
                    ctrl_q <= bus.in_ctrl;
                end
            end
            assign bus.out_ctrl = ctrl_q;
        end
    endgenerate

    assign bus.out_valid    = ex_valid;
    assign bus.out_pc       = ex_pc;
    assign bus.out_imm      = ex_imm;
    assign bus.out_rd       = ex_rd;
    assign bus.out_rs1      = ex_rs1;
    assign bus.out_rs2      = ex_rs2;
    assign bus.out_rs1_fp   = ex_rs1_fp;
    assign bus.out_rs2_fp   = ex_rs2_fp;
    assign bus.out_rs1_data = ex_rs1_data;
    assign bus.out_rs2_data = ex_rs2_data;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage_reg
//  Description : Self-checking bench for id_ex_stage_reg: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;
    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int NUM_WB = 2;
    localparam int CTRL_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .NUM_WB(NUM_WB), .CTRL_W(CTRL_W)) bus ();

    id_ex_stage_reg #(.XLEN(XLEN), .RA_W(RA_W), .NUM_WB(NUM_WB), .CTRL_W(CTRL_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected contents of the EX slot.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [RA_W-1:0]   rd;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic              f1;
        logic              f2;
        logic [XLEN-1:0]   d1;
        logic [XLEN-1:0]   d2;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    ent_t m;

    function automatic logic [XLEN-1:0] pick(input logic [RA_W-1:0] a, input logic fp,
                                             input logic [XLEN-1:0] dflt);
        for (int i = 0; i < NUM_WB; i++) begin
            if (bus.wb_en[i] && bus.wb_rd[i*RA_W +: RA_W] == a && bus.wb_fp[i] == fp &&
                !(a == '0 && !fp))
                return bus.wb_data[i*XLEN +: XLEN];
        end
        return dflt;
    endfunction

    function automatic logic [160:0] dut_payload();
        return {bus.out_pc, bus.out_imm, bus.out_rd, bus.out_rs1, bus.out_rs2,
                bus.out_rs1_fp, bus.out_rs2_fp, bus.out_rs1_data, bus.out_rs2_data,
                bus.out_ctrl};
    endfunction

    function automatic logic [160:0] mdl_payload();
        return {m.pc, m.imm, m.rd, m.rs1, m.rs2, m.f1, m.f2, m.d1, m.d2, m.ctrl};
    endfunction

    // Advance the model by one clock from the inputs seen just before the edge.
    task automatic tick();
        ent_t n;
        n = m;
        if (!rst) begin
            n = '0;
        end else if (bus.flush) begin
            n.valid = 1'b0;
        end else if (bus.in_valid && (!m.valid || bus.out_ready)) begin
            n.valid = 1'b1;
            n.pc    = bus.in_pc;
            n.imm   = bus.in_imm;
            n.rd    = bus.in_rd;
            n.rs1   = bus.in_rs1;
            n.rs2   = bus.in_rs2;
            n.f1    = bus.in_rs1_fp;
            n.f2    = bus.in_rs2_fp;
            n.ctrl  = bus.in_ctrl;
            n.d1    = pick(bus.in_rs1, bus.in_rs1_fp,
                           bus.in_rs1_fp ? bus.rs1_fp_data : bus.rs1_int_data);
            n.d2    = pick(bus.in_rs2, bus.in_rs2_fp,
                           bus.in_rs2_fp ? bus.rs2_fp_data : bus.rs2_int_data);
        end else if (m.valid && bus.out_ready) begin
            n.valid = 1'b0;
        end else if (m.valid) begin
            n.d1 = pick(m.rs1, m.f1, m.d1);
            n.d2 = pick(m.rs2, m.f2, m.d2);
        end
        @(posedge clk);
        #1;
        m = n;
    endtask

    task automatic set_idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.wb_en     = '0;
        bus.wb_fp     = '0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
    endtask

    task automatic drive_rand_payload();
        bus.in_pc        = $urandom;
        bus.in_imm       = $urandom;
        bus.in_rd        = RA_W'($urandom);
        bus.in_rs1       = RA_W'($urandom);
        bus.in_rs2       = RA_W'($urandom);
        bus.in_rs1_fp    = 1'($urandom);
        bus.in_rs2_fp    = 1'($urandom);
        bus.in_ctrl      = CTRL_W'($urandom);
        bus.rs1_int_data = $urandom;
        bus.rs2_int_data = $urandom;
        bus.rs1_fp_data  = $urandom;
        bus.rs2_fp_data  = $urandom;
    endtask

    task automatic test_reset();
        set_idle();
        drive_rand_payload();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b want 0", bus.out_valid);
        end
        checks++;
        if (dut_payload() !== '0) begin
            errors++;
            $display("FAIL reset_payload: got %h want 0", dut_payload());
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_int_forward();
        set_idle();
        drive_rand_payload();
        bus.in_valid  = 1'b1;
        bus.in_rs1    = 5'd5;
        bus.in_rs1_fp = 1'b0;
        bus.wb_en     = 2'b11;
        bus.wb_fp     = 2'b00;
        bus.wb_rd     = {5'd5, 5'd5};
        bus.wb_data   = {32'h1111_1111, 32'hAAAA_0000};
        tick();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_valid: got %0b want 1", bus.out_valid);
        end
        checks++;
        if (bus.out_rs1_data !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL fwd_priority: got %h want aaaa0000", bus.out_rs1_data);
        end
    endtask

    task automatic test_x0_class();
        logic [XLEN-1:0] i1, i2;
        set_idle();
        drive_rand_payload();
        i1 = 32'h0101_0101;
        i2 = 32'h0202_0202;
        bus.in_valid     = 1'b1;
        bus.in_rs1       = 5'd0;
        bus.in_rs1_fp    = 1'b0;
        bus.in_rs2       = 5'd3;
        bus.in_rs2_fp    = 1'b0;
        bus.rs1_int_data = i1;
        bus.rs2_int_data = i2;
        bus.wb_en        = 2'b11;
        bus.wb_fp        = 2'b10;
        bus.wb_rd        = {5'd3, 5'd0};
        bus.wb_data      = {32'h0000_BEEF, 32'h0000_DEAD};
        tick();
        checks++;
        if (bus.out_rs1_data !== i1) begin
            errors++;
            $display("FAIL x0_no_fwd: got %h want %h", bus.out_rs1_data, i1);
        end
        checks++;
        if (bus.out_rs2_data !== i2) begin
            errors++;
            $display("FAIL class_mismatch: got %h want %h", bus.out_rs2_data, i2);
        end
    endtask

    task automatic test_fp_f0();
        set_idle();
        drive_rand_payload();
        bus.in_valid    = 1'b1;
        bus.in_rs2      = 5'd0;
        bus.in_rs2_fp   = 1'b1;
        bus.rs2_fp_data = 32'h4000_0000;
        bus.wb_en       = 2'b01;
        bus.wb_fp       = 2'b01;
        bus.wb_rd       = '0;
        bus.wb_data     = {32'h0, 32'h3F80_0000};
        tick();
        checks++;
        if (bus.out_rs2_data !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL fp_f0_fwd: got %h want 3f800000", bus.out_rs2_data);
        end
    endtask

    task automatic test_stall_refresh();
        logic [XLEN-1:0] want;
        set_idle();
        drive_rand_payload();
        bus.in_valid     = 1'b1;
        bus.in_pc        = 32'h0000_0100;
        bus.in_imm       = 32'h0000_0055;
        bus.in_ctrl      = 16'hC0DE;
        bus.in_rs1       = 5'd7;
        bus.in_rs1_fp    = 1'b0;
        bus.rs1_int_data = 32'h0000_0077;
        tick();
        bus.out_ready = 1'b0;
        bus.in_pc     = 32'h0000_0200;
        bus.in_imm    = 32'h0000_0066;
        bus.in_ctrl   = 16'h1111;
        for (int c = 1; c <= 3; c++) begin
            bus.wb_en   = (c == 2) ? 2'b10 : 2'b00;
            bus.wb_fp   = 2'b00;
            bus.wb_rd   = {5'd7, 5'd0};
            bus.wb_data = {32'h0000_1234, 32'h0};
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready c%0d: got %0b want 0", c, bus.in_ready);
            end
            tick();
            want = (c >= 2) ? 32'h0000_1234 : 32'h0000_0077;
            checks++;
            if (bus.out_rs1_data !== want) begin
                errors++;
                $display("FAIL stall_refresh c%0d: got %h want %h", c, bus.out_rs1_data, want);
            end
            checks++;
            if ({bus.out_valid, bus.out_pc, bus.out_imm, bus.out_ctrl} !==
                {1'b1, 32'h0000_0100, 32'h0000_0055, 16'hC0DE}) begin
                errors++;
                $display("FAIL stall_hold c%0d: got %h/%h/%h/%h want 1/100/55/c0de", c,
                         bus.out_valid, bus.out_pc, bus.out_imm, bus.out_ctrl);
            end
        end
        set_idle();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        set_idle();
        drive_rand_payload();
        bus.in_valid = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.in_pc     = 32'h0000_0999;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: got %0b want 0", bus.out_valid);
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_capture: got %0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] pc;
        set_idle();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_rand_payload();
            pc = 32'h0000_1000 + XLEN'(k * 4);
            bus.in_pc = pc;
            tick();
            checks++;
            if ({bus.out_valid, bus.out_pc} !== {1'b1, pc}) begin
                errors++;
                $display("FAIL b2b_%0d: got %0b/%h want 1/%h", k, bus.out_valid, bus.out_pc, pc);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst           = ($urandom_range(0, 49) != 0);
            bus.flush     = ($urandom_range(0, 9) == 0);
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            drive_rand_payload();
            bus.in_rs1    = RA_W'($urandom_range(0, 3));
            bus.in_rs2    = RA_W'($urandom_range(0, 3));
            bus.wb_en     = NUM_WB'($urandom);
            bus.wb_fp     = NUM_WB'($urandom);
            for (int p = 0; p < NUM_WB; p++) begin
                bus.wb_rd[p*RA_W +: RA_W]   = RA_W'($urandom_range(0, 3));
                bus.wb_data[p*XLEN +: XLEN] = $urandom;
            end
            #1;
            checks++;
            if (bus.in_ready !== (!m.valid || bus.out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready %0d: got %0b want %0b", k, bus.in_ready,
                         (!m.valid || bus.out_ready));
            end
            tick();
            checks++;
            if (bus.out_valid !== m.valid) begin
                errors++;
                $display("FAIL rand_valid %0d: got %0b want %0b", k, bus.out_valid, m.valid);
            end
            if (m.valid) begin
                checks++;
                if (dut_payload() !== mdl_payload()) begin
                    errors++;
                    $display("FAIL rand_payload %0d: got %h want %h", k, dut_payload(),
                             mdl_payload());
                end
            end
        end
        rst = 1'b1;
        set_idle();
        tick();
    endtask

    initial begin
        m = '0;
        set_idle();
        drive_rand_payload();
        test_reset();
        test_int_forward();
        test_x0_class();
        test_fp_f0();
        test_stall_refresh();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
